dmem_responder: RTL and testbench
=================================

DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 256, number of 32-bit words in the array (power of two, >= 4).
REQ-002 SHALL have parameter LATENCY, default 3, number of BUSY cycles per access (>= 1).
REQ-003 SHALL have port CLK  input  1  single clock, all state updates on rising edge.
REQ-004 SHALL have port RESET  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port MEM_READ_EN  input  1  load request from EX stage.
REQ-006 SHALL have port MEM_WRITE_EN  input  1  store request from EX stage.
REQ-007 SHALL have port ADDRESS  input  32  byte address (ALU result).
REQ-008 SHALL have port WRITE_DATA  input  32  store data (forwarded rs2).
REQ-009 SHALL have port FUNC3  input  3  access size/sign per RV32I load/store encoding.
REQ-010 SHALL have port READ_DATA  output  32  formatted load result.
REQ-011 SHALL have port MEM_BUSYWAIT  output  1  stall request to pipeline.
REQ-012 SHALL have port MISALIGNED  output  1  misaligned-access flag, valid in DONE.

Function
REQ-013 SHALL implement FSM states IDLE, BUSY, DONE.
REQ-014 In IDLE with MEM_READ_EN or MEM_WRITE_EN high: MEM_BUSYWAIT = 1 combinationally same cycle; ADDRESS, WRITE_DATA, FUNC3 and request type captured; counter loaded LATENCY-1; next state BUSY.
REQ-015 Both enables high in IDLE: request treated as store; read ignored.
REQ-016 In BUSY: MEM_BUSYWAIT = 1; counter != 0 -> decrement; counter == 0 -> access performed on captured values, next state DONE.
REQ-017 Total MEM_BUSYWAIT-high cycles per access SHALL be exactly LATENCY+1.
REQ-018 In DONE: MEM_BUSYWAIT = 0, READ_DATA and MISALIGNED valid; next state IDLE unconditionally; enables sampled in DONE SHALL NOT start a new access (pipeline still holds the completed request).
REQ-019 A request present in the IDLE cycle following DONE SHALL start a new access (back-to-back supported).
REQ-020 Word index = ADDRESS[log2(DEPTH_WORDS)+1:2]; upper address bits ignored (aliasing wrap-around).
REQ-021 Loads: 000 LB sign-extend, 001 LH sign-extend, 010 LW, 100 LBU zero-extend, 101 LHU zero-extend; byte lane from ADDRESS[1:0], half from ADDRESS[1]; other codes as LW.
REQ-022 Stores: 000 SB writes one byte lane, 001 SH writes half selected by ADDRESS[1], 010 SW full word; other codes as SW; unselected lanes unchanged.
REQ-023 READ_DATA SHALL hold its last value outside DONE; stores SHALL NOT change READ_DATA.
REQ-024 MISALIGNED SHALL be 0 outside DONE.

Reset
REQ-025 RESET low at a rising edge: state IDLE, counter 0, READ_DATA 0, MISALIGNED 0; MEM_BUSYWAIT 0 while RESET low.
REQ-026 Reset mid-access: pending store discarded (array unchanged), pending load result discarded.
REQ-027 Array contents SHALL NOT be reset.

Configuration
REQ-028 Macro DMEM_MISALIGN_TRAP_EN defined: LH/LHU/SH with ADDRESS[0]=1, or LW/SW with ADDRESS[1:0]!=0, SHALL perform no array write, set READ_DATA 0 and MISALIGNED 1 in DONE; latency unchanged.
REQ-029 Macro undefined: MISALIGNED tied 0; halfword ignores ADDRESS[0], word ignores ADDRESS[1:0].

Verification (LATENCY=3, DEPTH_WORDS=256)
REQ-030 SW 0xDEADBEEF to 0x10, then LW 0x10 -> MEM_BUSYWAIT high exactly 4 cycles each, READ_DATA=0xDEADBEEF in DONE.
REQ-031 After REQ-030, SB 0x7F to 0x12, LB 0x13 -> 0xFFFFFFDE; LBU 0x13 -> 0x000000DE; LW 0x10 -> 0xDE7FBEEF.
REQ-032 LH 0x12 after REQ-031 -> 0xFFFFDE7F; LHU 0x12 -> 0x0000DE7F.
REQ-033 Enables held high through DONE and one further cycle -> exactly two accesses, second busywait starts cycle after DONE; LW 0x410 returns word at 0x10 (wrap).
REQ-034 RESET low on second BUSY cycle of SW 0x1 to 0x20 -> MEM_BUSYWAIT 0, state IDLE; later LW 0x20 returns prior contents.
REQ-035 With DMEM_MISALIGN_TRAP_EN, SW to 0x22 -> MISALIGNED=1 in DONE only, word 0x20 unchanged; without macro, same store writes word 0x20.

Source files
------------

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder for an RV32I pipeline: IDLE/BUSY/DONE handshake with byte-lane
// loads and stores. Optional macro DMEM_MISALIGN_TRAP_EN flags and suppresses misaligned accesses.
module dmem_responder #(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned LATENCY     = 3
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        MEM_READ_EN,
  input  logic        MEM_WRITE_EN,
  input  logic [31:0] ADDRESS,
  input  logic [31:0] WRITE_DATA,
  input  logic [2:0]  FUNC3,
  output logic [31:0] READ_DATA,
  output logic        MEM_BUSYWAIT,
  output logic        MISALIGNED
);

  localparam int unsigned IdxW = $clog2(DEPTH_WORDS);
  localparam int unsigned CntW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CntW-1:0] CntLoad = CntW'(LATENCY - 1);

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;
  typedef enum logic [1:0] {SzByte, SzHalf, SzWord} size_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [IdxW+1:0] addr_q, addr_d;
  logic [31:0]     wdata_q, wdata_d;
  logic [2:0]      func3_q, func3_d;
  logic            store_q, store_d;
  logic [31:0]     rdata_q, rdata_d;
  logic            misal_q, misal_d;
  logic [31:0]     mem_q [DEPTH_WORDS];

  logic        busy;
  logic        mem_we;
  size_e       size;
  logic        misal;
  logic [31:0] word_rd;
  logic [7:0]  byte_rd;
  logic [15:0] half_rd;
  logic [31:0] load_val;
  logic [3:0]  st_be;
  logic [31:0] st_data;

  // Address bits above the array index alias onto the same words.
  logic unused_addr;
  assign unused_addr = ^ADDRESS[31:IdxW+2];

  // Load and store encodings differ for codes 100/101, so decode size per request type.
  always_comb begin
    size = SzWord;
    if (store_q) begin
      case (func3_q)
        3'b000:  size = SzByte;
        3'b001:  size = SzHalf;
        default: size = SzWord;
      endcase
    end else begin
      case (func3_q)
        3'b000, 3'b100: size = SzByte;
        3'b001, 3'b101: size = SzHalf;
        default:        size = SzWord;
      endcase
    end
  end

`ifdef DMEM_MISALIGN_TRAP_EN
  assign misal = ((size == SzHalf) && addr_q[0]) || ((size == SzWord) && (addr_q[1:0] != 2'b00));
`else
  assign misal = 1'b0;
`endif

  assign word_rd = mem_q[addr_q[IdxW+1:2]];
  assign half_rd = addr_q[1] ? word_rd[31:16] : word_rd[15:0];

  always_comb begin
    byte_rd = word_rd[7:0];
    case (addr_q[1:0])
      2'd0:    byte_rd = word_rd[7:0];
      2'd1:    byte_rd = word_rd[15:8];
      2'd2:    byte_rd = word_rd[23:16];
      default: byte_rd = word_rd[31:24];
    endcase
  end

  always_comb begin
    load_val = word_rd;
    case (func3_q)
      3'b000:  load_val = {{24{byte_rd[7]}}, byte_rd};
      3'b001:  load_val = {{16{half_rd[15]}}, half_rd};
      3'b100:  load_val = {24'h0, byte_rd};
      3'b101:  load_val = {16'h0, half_rd};
      default: load_val = word_rd;
    endcase
  end

  // Replicate store data across lanes; the byte enables pick the lanes actually written.
  always_comb begin
    st_be   = 4'b1111;
    st_data = wdata_q;
    case (size)
      SzByte: begin
        st_be   = 4'b0001 << addr_q[1:0];
        st_data = {4{wdata_q[7:0]}};
      end
      SzHalf: begin
        st_be   = addr_q[1] ? 4'b1100 : 4'b0011;
        st_data = {2{wdata_q[15:0]}};
      end
      default: begin
        st_be   = 4'b1111;
        st_data = wdata_q;
      end
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    func3_d = func3_q;
    store_d = store_q;
    rdata_d = rdata_q;
    misal_d = 1'b0;
    busy    = 1'b0;
    mem_we  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (MEM_READ_EN || MEM_WRITE_EN) begin
          busy    = 1'b1;
          addr_d  = ADDRESS[IdxW+1:0];
          wdata_d = WRITE_DATA;
          func3_d = FUNC3;
          store_d = MEM_WRITE_EN;
          cnt_d   = CntLoad;
          state_d = StBusy;
        end
      end
      StBusy: begin
        busy = 1'b1;
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          state_d = StDone;
          misal_d = misal;
          mem_we  = store_q && !misal;
          if (misal) begin
            rdata_d = '0;
          end else if (!store_q) begin
            rdata_d = load_val;
          end
        end
      end
      StDone: begin
        // The pipeline still presents the finished request here; never restart on it.
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      func3_q <= '0;
      store_q <= 1'b0;
      rdata_q <= '0;
      misal_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      func3_q <= func3_d;
      store_q <= store_d;
      rdata_q <= rdata_d;
      misal_q <= misal_d;
    end
  end

  // Array has no reset; a reset edge cancels any write still pending.
  always_ff @(posedge CLK) begin
    if (RESET && mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (st_be[b]) begin
          mem_q[addr_q[IdxW+1:2]][8*b +: 8] <= st_data[8*b +: 8];
        end
      end
    end
  end

  assign MEM_BUSYWAIT = RESET && busy;
  assign READ_DATA    = rdata_q;
  assign MISALIGNED   = misal_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Randomized bench for dmem_responder against a byte-addressed reference memory model.
// Honours DMEM_MISALIGN_TRAP_EN when the DUT is built with it.
module tb_dmem_responder;

  localparam int unsigned Depth   = 256;
  localparam int unsigned Latency = 3;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        MEM_READ_EN;
  logic        MEM_WRITE_EN;
  logic [31:0] ADDRESS;
  logic [31:0] WRITE_DATA;
  logic [2:0]  FUNC3;
  logic [31:0] READ_DATA;
  logic        MEM_BUSYWAIT;
  logic        MISALIGNED;

  int unsigned n_total = 0;
  int unsigned n_bad   = 0;

  logic [31:0] mem_m [Depth];
  logic [31:0] exp_rd;

  dmem_responder #(
    .DEPTH_WORDS(Depth),
    .LATENCY    (Latency)
  ) u_dut (
    .CLK         (CLK),
    .RESET       (RESET),
    .MEM_READ_EN (MEM_READ_EN),
    .MEM_WRITE_EN(MEM_WRITE_EN),
    .ADDRESS     (ADDRESS),
    .WRITE_DATA  (WRITE_DATA),
    .FUNC3       (FUNC3),
    .READ_DATA   (READ_DATA),
    .MEM_BUSYWAIT(MEM_BUSYWAIT),
    .MISALIGNED  (MISALIGNED)
  );

  always #5 CLK = ~CLK;

  initial begin
    #2000000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic int size_of(input bit st, input logic [2:0] f3);
    if (st) return (f3 == 3'b000) ? 1 : (f3 == 3'b001) ? 2 : 4;
    return (f3 == 3'b000 || f3 == 3'b100) ? 1 : (f3 == 3'b001 || f3 == 3'b101) ? 2 : 4;
  endfunction

  function automatic bit is_misal(input bit st, input logic [31:0] a, input logic [2:0] f3);
`ifdef DMEM_MISALIGN_TRAP_EN
    return (int'(a[1:0]) % size_of(st, f3)) != 0;
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [31:0] load_fmt(input logic [31:0] w, input logic [31:0] a,
                                           input logic [2:0] f3);
    int sz = size_of(1'b0, f3);
    int base = (int'(a[1:0]) / sz) * sz;
    logic [31:0] raw = w >> (8 * base);
    if (sz == 1) begin
      raw = raw & 32'hFF;
      if (!f3[2] && raw[7]) raw = raw | 32'hFFFF_FF00;
    end else if (sz == 2) begin
      raw = raw & 32'hFFFF;
      if (!f3[2] && raw[15]) raw = raw | 32'hFFFF_0000;
    end
    return raw;
  endfunction

  // One full request: model update, then busy-length, hold and result checks.
  task automatic do_acc(input string tag, input bit we, input bit re, input logic [31:0] a,
                        input logic [31:0] d, input logic [2:0] f3);
    int          idx = int'(a[9:2]);
    int          sz = size_of(we, f3);
    int          base = (int'(a[1:0]) / sz) * sz;
    bit          mis = is_misal(we, a, f3);
    logic [31:0] prev = exp_rd;
    int          busy_n = 0;
    bit          hold_bad = 1'b0;
    if (mis) begin
      exp_rd = '0;
    end else if (we) begin
      for (int i = 0; i < sz; i++) mem_m[idx][8*(base+i) +: 8] = d[8*i +: 8];
    end else begin
      exp_rd = load_fmt(mem_m[idx], a, f3);
    end
    MEM_WRITE_EN = we;
    MEM_READ_EN  = re;
    ADDRESS      = a;
    WRITE_DATA   = d;
    FUNC3        = f3;
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK);
      if (!MEM_BUSYWAIT) break;
      busy_n++;
      if (MISALIGNED || READ_DATA !== prev) hold_bad = 1'b1;
    end
    check_eq({tag, "_busy"}, busy_n, Latency + 1);
    check_eq({tag, "_hold"}, hold_bad, 1'b0);
    check_eq({tag, "_rd"}, READ_DATA, exp_rd);
    check_eq({tag, "_mis"}, MISALIGNED, mis);
    MEM_WRITE_EN = 1'b0;
    MEM_READ_EN  = 1'b0;
    @(posedge CLK);
    #1;
  endtask

  initial begin
    logic [10:0] pat;
    RESET        = 1'b0;
    MEM_READ_EN  = 1'b1;
    MEM_WRITE_EN = 1'b1;
    ADDRESS      = 32'h10;
    WRITE_DATA   = '0;
    FUNC3        = 3'b010;
    exp_rd       = '0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    check_eq("rst_busy", MEM_BUSYWAIT, 1'b0);
    check_eq("rst_rd", READ_DATA, 32'h0);
    check_eq("rst_mis", MISALIGNED, 1'b0);
    @(posedge CLK);
    #1;
    RESET        = 1'b1;
    MEM_READ_EN  = 1'b0;
    MEM_WRITE_EN = 1'b0;

    for (int i = 0; i < int'(Depth); i++) do_acc("init", 1'b1, 1'b0, 32'(i * 4), $urandom, 3'b010);

    do_acc("sw10", 1'b1, 1'b0, 32'h10, 32'hDEADBEEF, 3'b010);
    do_acc("lw10", 1'b0, 1'b1, 32'h10, 32'h0, 3'b010);
    check_eq("lw10_lit", READ_DATA, 32'hDEADBEEF);
    do_acc("sb12", 1'b1, 1'b0, 32'h12, 32'h7F, 3'b000);
    do_acc("lb13", 1'b0, 1'b1, 32'h13, 32'h0, 3'b000);
    check_eq("lb13_lit", READ_DATA, 32'hFFFFFFDE);
    do_acc("lbu13", 1'b0, 1'b1, 32'h13, 32'h0, 3'b100);
    check_eq("lbu13_lit", READ_DATA, 32'h000000DE);
    do_acc("lw10b", 1'b0, 1'b1, 32'h10, 32'h0, 3'b010);
    check_eq("lw10b_lit", READ_DATA, 32'hDE7FBEEF);
    do_acc("lh12", 1'b0, 1'b1, 32'h12, 32'h0, 3'b001);
    check_eq("lh12_lit", READ_DATA, 32'hFFFFDE7F);
    do_acc("lhu12", 1'b0, 1'b1, 32'h12, 32'h0, 3'b101);
    check_eq("lhu12_lit", READ_DATA, 32'h0000DE7F);

    // Enables held through DONE and the following IDLE: exactly two back-to-back loads.
    MEM_READ_EN = 1'b1;
    ADDRESS     = 32'h410;
    FUNC3       = 3'b010;
    exp_rd      = mem_m[4];
    pat         = '0;
    for (int i = 0; i < 11; i++) begin
      @(negedge CLK);
      pat[i] = MEM_BUSYWAIT;
      if (i == 4 || i == 9) check_eq("b2b_rd", READ_DATA, exp_rd);
      @(posedge CLK);
      #1;
      if (i == 5) MEM_READ_EN = 1'b0;
    end
    check_eq("b2b_pattern", 32'(pat), 32'(11'b00111101111));
    check_eq("wrap_lit", READ_DATA, 32'hDE7FBEEF);

    // Reset on the second BUSY cycle of a store discards it.
    MEM_WRITE_EN = 1'b1;
    ADDRESS      = 32'h20;
    WRITE_DATA   = 32'h1;
    @(posedge CLK);
    #1;
    @(posedge CLK);
    #1;
    RESET        = 1'b0;
    MEM_WRITE_EN = 1'b0;
    @(negedge CLK);
    check_eq("midrst_busy", MEM_BUSYWAIT, 1'b0);
    @(posedge CLK);
    #1;
    RESET  = 1'b1;
    exp_rd = '0;
    @(negedge CLK);
    check_eq("midrst_rd", READ_DATA, 32'h0);
    check_eq("midrst_idle", MEM_BUSYWAIT, 1'b0);
    @(posedge CLK);
    #1;
    do_acc("lw20", 1'b0, 1'b1, 32'h20, 32'h0, 3'b010);

    do_acc("sw22", 1'b1, 1'b0, 32'h22, 32'h12345678, 3'b010);
    do_acc("lw20b", 1'b0, 1'b1, 32'h20, 32'h0, 3'b010);
`ifndef DMEM_MISALIGN_TRAP_EN
    check_eq("sw22_lit", READ_DATA, 32'h12345678);
`endif

    for (int n = 0; n < 400; n++) begin
      int          kind = int'($urandom_range(0, 3));
      logic [31:0] a = $urandom;
      logic [2:0]  f3 = 3'($urandom_range(0, 7));
      bit          we = (kind == 1 || kind == 2);
      bit          re = (kind != 1);
      do_acc("rnd", we, re, a, $urandom, f3);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
